// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trng_pkg
// Brief    : Shared constants, debias state type and helpers for TRNG blocks
// Revision : 1.0 - initial release
// ============================================================================
package trng_pkg;

    localparam int c_def_channels  = 3;
    localparam int c_def_width     = 8;
    localparam int c_def_depth     = 4;
    localparam int c_def_rep_limit = 16;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } debias_state_t;

    // Level counters need one extra bit so that "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trng_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trng_fifo
// Brief    : WIDTH x DEPTH circular buffer with push/pop/flush and level
// Revision : 1.0 - initial release
// ============================================================================
module trng_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int DEPTH = c_def_depth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          full,
    output logic                          empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = level_width(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_max = c_lvl_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_rd;
    logic               w_wr;

    assign empty = (r_level == '0);
    assign full  = (r_level == c_lvl_max);
    assign w_rd  = pop && !empty;
    // A pop frees the head slot in the same edge, so a full buffer can still accept.
    assign w_wr  = push && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/trng_collector.sv
`default_nettype none
// ============================================================================
// Module   : trng_collector
// Brief    : Multi-oscillator entropy collector: sync, XOR mix, von Neumann
//            debias, repetition health test, word packing and output FIFO
// Revision : 1.0 - initial release
// ============================================================================
module trng_collector
    import trng_pkg::*;
#(
    parameter int CHANNELS  = c_def_channels,
    parameter int WIDTH     = c_def_width,
    parameter int DEPTH     = c_def_depth,
    parameter int REP_LIMIT = c_def_rep_limit
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    output logic                          osc_en,
    input  logic [CHANNELS-1:0]           raw_in,
    input  logic                          debias_en,
    output logic [WIDTH-1:0]              word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic                          overflow,
    output logic                          health_fail
);

    localparam int                c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [7:0]        c_rep_limit = 8'(REP_LIMIT);

    logic                r_osc_en;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic                r_mix;
    logic [1:0]          r_vcnt;
    logic                w_m_valid;

    debias_state_t       r_db_state;
    debias_state_t       w_db_eff;
    debias_state_t       w_db_nxt;
    logic                r_first;
    logic                w_first_nxt;
    logic                r_debias_q;
    logic                w_toggle;
    logic                w_accept;
    logic                w_bit;

    logic [7:0]          r_run;
    logic [7:0]          w_run_nxt;
    logic                r_last_m;
    logic                r_health;

    logic [WIDTH-1:0]    r_sr;
    logic [WIDTH-1:0]    w_word;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                r_overflow;

    // Synchroniser and mixer freeze while the oscillators are off; the
    // fill counter discards stale stages after a restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_osc_en <= 1'b0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_mix    <= 1'b0;
            r_vcnt   <= 2'd0;
        end else begin
            r_osc_en <= en;
            if (r_osc_en) begin
                r_sync1 <= raw_in;
                r_sync2 <= r_sync1;
                r_mix   <= ^r_sync2;
                if (r_vcnt != 2'd3) r_vcnt <= r_vcnt + 2'd1;
            end else begin
                r_vcnt <= 2'd0;
            end
        end
    end

    assign w_m_valid = r_osc_en && (r_vcnt == 2'd3);
    assign w_toggle  = (debias_en != r_debias_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_state <= IDLE;
            r_first    <= 1'b0;
            r_debias_q <= 1'b0;
        end else begin
            r_db_state <= w_db_nxt;
            r_first    <= w_first_nxt;
            r_debias_q <= debias_en;
        end
    end

    always_comb begin
        w_db_eff    = w_toggle ? IDLE : r_db_state;
        w_db_nxt    = w_db_eff;
        w_first_nxt = r_first;
        w_accept    = 1'b0;
        w_bit       = 1'b0;
        if (!en || r_health) begin
            w_db_nxt = IDLE;
        end else if (w_m_valid) begin
            if (!debias_en) begin
                w_accept = 1'b1;
                w_bit    = r_mix;
            end else begin
                case (w_db_eff)
                    IDLE: begin
                        w_db_nxt    = HAVE_FIRST;
                        w_first_nxt = r_mix;
                    end
                    HAVE_FIRST: begin
                        w_db_nxt = IDLE;
                        if (r_first != r_mix) begin
                            w_accept = 1'b1;
                            w_bit    = r_first;
                        end
                    end
                    default: w_db_nxt = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        if ((r_run == 8'd0) || (r_mix != r_last_m)) w_run_nxt = 8'd1;
        else if (r_run == 8'hFF)                    w_run_nxt = r_run;
        else                                        w_run_nxt = r_run + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_run    <= 8'd0;
            r_last_m <= 1'b0;
            r_health <= 1'b0;
        end else if (w_m_valid) begin
            r_run    <= w_run_nxt;
            r_last_m <= r_mix;
            if (w_run_nxt >= c_rep_limit) r_health <= 1'b1;
        end
    end

    assign w_word = {r_sr[WIDTH-2:0], w_bit};
    assign w_push = w_accept && (r_bit_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (!rst_n || !en || r_health) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_sr      <= w_word;
            r_bit_cnt <= (r_bit_cnt == c_cnt_max) ? '0 : r_bit_cnt + c_cnt_one;
        end
    end

    assign w_pop = !w_empty && word_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end

    trng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (r_health),
        .push      (w_push),
        .push_data (w_word),
        .pop       (w_pop),
        .head      (word_out),
        .level     (fifo_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign osc_en      = r_osc_en;
    assign word_valid  = !w_empty;
    assign overflow    = r_overflow;
    assign health_fail = r_health;

endmodule
`default_nettype wire
